decode_pipe: RTL
================

Name: decode_pipe

Overview:
- Registered, parametrised successor to the combinational MIPS field decoder. It accepts 32-bit instructions over a valid/ready handshake and splits them into op/Rs/Rt/Rd/shamt/func/offset fields, using the same field-zeroing rules as the current decoder.
- Adds the following on top of that decoder: one pipeline register, a 1-entry skid buffer for full throughput under backpressure, J-type target extraction, a parametrised-width extended offset, synchronous flush, and a saturating count of retired decodes.
- Sits between instruction fetch and the register-file read stage.

Parameters:
- OFF_W, 32: width of the extended offset output; legal range 16..64.
- SIGN_EXT, 1: 1 means the offset is sign-extended; 0 means zero-extended.
- CNT_W, 16: width of the retired-decode counter.

Ports:
- clk_i, input, 1: clock; rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush_i, input, 1: synchronous flush; drops all held instructions.
- in_valid_i, input, 1: ins_i is valid this cycle.
- in_ready_o, output, 1: the block can accept an instruction this cycle.
- ins_i, input, 32: instruction word.
- out_valid_o, output, 1: decoded fields are valid.
- out_ready_i, input, 1: downstream accepts the decoded fields.
- op_o, output, 6: opcode.
- rs_o, output, 5: source register.
- rt_o, output, 5: second source register.
- rd_o, output, 5: destination register.
- shamt_o, output, 5: shift amount.
- func_o, output, 6: function code.
- offset_o, output, OFF_W: extended immediate.
- target_o, output, 26: jump target.
- fmt_o, output, 2: instruction format; 00 = R, 01 = I, 10 = J.
- ill_o, output, 1: illegal instruction flag (see Optional Feature).
- count_o, output, CNT_W: number of retired decodes.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid_o = 0 and in_ready_o = 1.
  - All field outputs, fmt_o, ill_o and count_o = 0.
  - Skid buffer is emptied.
- Field rules, applied at capture time:
  - R-type (op == 0): rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], func = [5:0]; offset = 0, target = 0, fmt = 00.
  - J-type (op == 2 or 3): target = [25:0]; rs, rt, rd, shamt, func and offset = 0; fmt = 10.
  - I-type (any other op): rs = [25:21], rd = [20:16], offset = ext([15:0]); rt, shamt, func and target = 0; fmt = 01.
  - ext(): sign- or zero-extends to OFF_W according to SIGN_EXT.
- Handshakes:
  - An input transfer occurs when in_valid_i and in_ready_o are both high.
  - An output transfer occurs when out_valid_o and out_ready_i are both high.
- Latency: 1 cycle. An instruction accepted on edge N appears on the outputs after edge N; out_valid_o is high during cycle N+1.
- Throughput: one instruction per cycle while out_ready_i stays high.
- Skid buffer:
  - Accepting while the output register is full and the output is not draining pushes the decoded entry into the skid slot.
  - in_ready_o = !skid_full. It is a registered signal with no combinational path from out_ready_i.
  - When the output drains, the skid entry moves to the output register, and the new input (if any) enters the skid slot.
  - Order is strictly FIFO.
  - While the output is stalled (out_valid_o = 1, out_ready_i = 0), the output fields stay stable.
- Flush (flush_i = 1 at an edge):
  - Clears out_valid_o and the skid buffer.
  - Any input presented in the same cycle is discarded.
  - in_ready_o = 1 in the next cycle.
  - count_o is not changed.
  - Flush has priority over all transfers.
- count_o: increments on each output transfer and saturates at 2^CNT_W − 1.
- Simultaneous input and output transfer with an empty skid buffer: the output register reloads with the new instruction; no bubble is inserted.
- Reset asserted mid-stall: the held instruction is lost.
- Only decoded fields are stored. Raw instruction bits are not retained.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - ill_o = 1 for any op outside {0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 35, 43}.
  - ill_o = 1 for op 0 with func outside {0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}.
  - ill_o is registered alongside the fields.
  - Illegal words still pass through and are counted.
- Undefined: ill_o is tied to 0 and no check logic is built.

Test Plan:
- R-type: ins 0x03E74810 with out_ready held 1 → one cycle later op 0, rs 31, rt 7, rd 9, shamt 0, func 16, offset 0, fmt 00, count 1.
- I-type: ins 0x8C280020 (LW) → op 35, rs 1, rd 8, rt 0, offset 32, fmt 01. Then ins 0x2028FFFF → offset 0xFFFFFFFF with SIGN_EXT = 1, and 0x0000FFFF with SIGN_EXT = 0.
- J-type: ins 0x0C000123 → op 3, target 0x0000123, fmt 10, all other fields 0.
- Backpressure:
  - Drive 4 back-to-back instructions with out_ready = 0 → the first is held, the second goes to skid, in_ready drops the next cycle, and the 3rd is held at the input.
  - Release out_ready → the instructions emerge in order, 1 per cycle, and count ends at 4.
- Flush while skid is full and in_valid = 1 → the next cycle has out_valid 0 and in_ready 1; count is unchanged.
- Corner cases:
  - Async reset pulsed mid-stall → all outputs read 0 with no clock edge.
  - With DECODE_ILLEGAL_EN defined, op 0x3F → ill_o = 1.
  - With CNT_W = 2 and 5 transfers, count saturates at 3.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: registered MIPS field decoder with a 1-entry skid buffer, J-target
//   extraction, parametrised offset extension, sync flush and a saturating retire count.
// Latency: 1 cycle from input handshake to out_valid_o.
// Backpressure: in_ready_o = !skid_full, registered, so there is no combinational path
//   from out_ready_i; a stalled output keeps its fields stable.
//
// Ports:
//   clk_i, rst_n                        clock (rising edge), async active-low reset
//   flush_i                             sync flush: drops output + skid entries, count kept
//   in_valid_i / in_ready_o / ins_i     instruction input handshake
//   out_valid_o / out_ready_i           decoded-field output handshake
//   op_o rs_o rt_o rd_o shamt_o func_o  decoded fields (zeroed per instruction format)
//   offset_o [OFF_W]                    sign/zero extended immediate (SIGN_EXT)
//   target_o [26]                       J-type target
//   fmt_o                               00 = R, 01 = I, 10 = J
//   ill_o                               illegal opcode/func flag
//   count_o [CNT_W]                     saturating count of output transfers
//
// Optional feature macro: DECODE_ILLEGAL_EN builds the illegal-instruction check;
// when undefined, ill_o is tied to 0.
module decode_pipe #(
  parameter int OFF_W    = 32,
  parameter int SIGN_EXT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      ins_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [5:0]       op_o,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       shamt_o,
  output logic [5:0]       func_o,
  output logic [OFF_W-1:0] offset_o,
  output logic [25:0]      target_o,
  output logic [1:0]       fmt_o,
  output logic             ill_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Only decoded fields are held; raw instruction bits are never stored.
  typedef struct packed {
    logic [5:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       func;
    logic [OFF_W-1:0] offset;
    logic [25:0]      target;
    logic [1:0]       fmt;
    logic             ill;
  } dec_t;

  dec_t             dec_in;
  dec_t             out_q;
  dec_t             skid_q;
  logic             out_vld_q;
  logic             skid_full_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OFF_W-1:0] ext_off;
  logic             ill_in;
  logic             in_xfer;
  logic             out_xfer;

  // Immediate extension via casts so OFF_W = 16 needs no zero-width replication.
  always_comb begin
    if (SIGN_EXT != 0) ext_off = OFF_W'(signed'(ins_i[15:0]));
    else               ext_off = OFF_W'(ins_i[15:0]);
  end

`ifdef DECODE_ILLEGAL_EN
  always_comb begin
    ill_in = 1'b0;
    if (ins_i[31:26] == 6'd0)
      ill_in = !(ins_i[5:0] inside {6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd33, 6'd34, 6'd35,
                                    6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43});
    else
      ill_in = !(ins_i[31:26] inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12,
                                      6'd13, 6'd14, 6'd15, 6'd35, 6'd43});
  end
`else
  assign ill_in = 1'b0;
`endif

  // Field split with per-format zeroing. I-type routes [20:16] to rd, not rt.
  always_comb begin
    dec_in     = '0;
    dec_in.op  = ins_i[31:26];
    dec_in.ill = ill_in;
    case (ins_i[31:26])
      6'd0: begin
        dec_in.rs    = ins_i[25:21];
        dec_in.rt    = ins_i[20:16];
        dec_in.rd    = ins_i[15:11];
        dec_in.shamt = ins_i[10:6];
        dec_in.func  = ins_i[5:0];
        dec_in.fmt   = FMT_R;
      end
      6'd2, 6'd3: begin
        dec_in.target = ins_i[25:0];
        dec_in.fmt    = FMT_J;
      end
      default: begin
        dec_in.rs     = ins_i[25:21];
        dec_in.rd     = ins_i[20:16];
        dec_in.offset = ext_off;
        dec_in.fmt    = FMT_I;
      end
    endcase
  end

  assign in_ready_o = !skid_full_q;
  assign in_xfer    = in_valid_i && !skid_full_q;
  assign out_xfer   = out_vld_q && out_ready_i;

  // Skid only fills while the output register is full and stalled, so skid_full
  // implies out_vld; when the output frees up the skid entry always goes first.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (flush_i) begin
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (out_xfer || !out_vld_q) begin
      if (skid_full_q) begin
        out_q       <= skid_q;
        out_vld_q   <= 1'b1;
        skid_full_q <= 1'b0;
      end else if (in_xfer) begin
        out_q     <= dec_in;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q      <= dec_in;
      skid_full_q <= 1'b1;
    end
  end

  // Flush outranks any output transfer in the same cycle, so it is not counted.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!flush_i && out_xfer && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid_o = out_vld_q;
  assign op_o        = out_q.op;
  assign rs_o        = out_q.rs;
  assign rt_o        = out_q.rt;
  assign rd_o        = out_q.rd;
  assign shamt_o     = out_q.shamt;
  assign func_o      = out_q.func;
  assign offset_o    = out_q.offset;
  assign target_o    = out_q.target;
  assign fmt_o       = out_q.fmt;
  assign ill_o       = out_q.ill;
  assign count_o     = cnt_q;

endmodule
